axi_lite_slave_regs: RTL

// AXI4-Lite responder (slave) exposing NUM_REGS x DATA_WIDTH read/write registers.
// It is the peer of our AXI4-Lite master on axi_lite_if. The register contents drive

---
 rtl/axi_lite_slave_regs_if.sv | 34 +++
 rtl/axi_lite_slave_regs.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master and the register-file responder.
// The master modport drives requests; the slave modport drives ready/response signals.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder with NUM_REGS byte-writable registers, flattened onto regs_o.
// Write and read channels are served by independent two-state FSMs.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite_if.slave                      bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int         IDX_W       = $clog2(NUM_REGS);
  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 2) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[2 +: IDX_W];
  endfunction

  // A held beat takes precedence over the live bus value, letting AW and W arrive in either order.
  assign w_aw_hs   = bus.awvalid & w_awready;
  assign w_w_hs    = bus.wvalid & w_wready;
  assign w_ar_hs   = bus.arvalid & w_arready;
  assign w_wr_addr = r_aw_held ? r_awaddr : bus.awaddr;
  assign w_wr_data = r_w_held ? r_wdata : bus.wdata;
  assign w_wr_strb = r_w_held ? r_wstrb : bus.wstrb;
  assign w_wr_ok   = in_range(w_wr_addr);
  assign w_commit  = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (bus.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (bus.rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Handshake outputs are gated by rst so they read 0 during reset, even before the first edge.
  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    if (rst) begin
      w_awready = (r_wstate == W_IDLE) & ~r_aw_held;
      w_wready  = (r_wstate == W_IDLE) & ~r_w_held;
      w_bvalid  = (r_wstate == W_RESP);
      w_arready = (r_rstate == R_IDLE);
      w_rvalid  = (r_rstate == R_DATA);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_wr_ok) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_wr_strb[b]) r_regs[reg_idx(w_wr_addr)][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end else begin
      if (w_aw_hs) r_aw_held <= 1'b1;
      if (w_w_hs)  r_w_held  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= bus.awaddr;
    if (w_w_hs) begin
      r_wdata <= bus.wdata;
      r_wstrb <= bus.wstrb;
    end
  end

  // Non-blocking sampling gives the pre-commit value on a same-edge read/write collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (w_ar_hs) begin
      r_rdata <= in_range(bus.araddr) ? r_regs[reg_idx(bus.araddr)] : '0;
      r_rresp <= in_range(bus.araddr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bus.awready = w_awready;
  assign bus.wready  = w_wready;
  assign bus.bvalid  = w_bvalid;
  assign bus.bresp   = r_bresp;
  assign bus.arready = w_arready;
  assign bus.rvalid  = w_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end
endmodule
